pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline. Drives the Stall/Flush inputs of PC, IF/ID, ID/EX,
//  EX/MEM and MEM/WB registers from load-use hazards, taken branches/jumps resolved in EX, and a multi-cycle

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 41 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 11 +
 rtl/pipeline_hazard_ctrl_dmem_wait_fsm.sv | 63 ++++++
 rtl/pipeline_hazard_ctrl.sv | 93 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The FSM encodings and REG_ZERO match the values used by the other pipeline blocks.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] M_IDLE   = 2'd0;
  localparam logic [1:0] M_WAIT   = 2'd1;
  localparam logic [1:0] M_ERR    = 2'd2;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0] IFIDRs1;
    logic [4:0] IFIDRs2;
    logic       IFIDUseRs1;
    logic       IFIDUseRs2;
    logic       IDEXMemRead;
    logic [4:0] IDEXRegRd;
    logic       EXRedirect;
    logic       EXMEMMemRead;
    logic       EXMEMMemWrite;
    logic       DMemReady;
  } haz_req_t;

  typedef struct packed {
    logic DMemReq;
    logic PCStall;
    logic IFIDStall;
    logic IDEXStall;
    logic EXMEMStall;
    logic MEMWBStall;
    logic IFIDFlush;
    logic IDEXFlush;
    logic EXMEMFlush;
    logic MEMWBFlush;
  } haz_rsp_t;

  function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                   input logic [4:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard bus between the pipeline and its stall/flush controller.
// The controller (master) owns rsp; the pipeline (slave) owns req.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  haz_req_t req;
  haz_rsp_t rsp;

  modport master (input req, output rsp);
  modport slave  (output req, input rsp);
endinterface

// File: rtl/pipeline_hazard_ctrl_dmem_wait_fsm.sv
// Tracks consecutive data-memory wait cycles and latches a sticky timeout error.
// wcnt holds the number of wait cycles already completed in the current access.
module dmem_wait_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       memop,
  input  logic       dmem_ready,
  output logic [1:0] state,
  output logic       mem_error
);

  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [WCNT_W-1:0] wcnt;
  logic              last_wait;

  // The cycle currently waiting is number wcnt+1; once that reaches the
  // limit, it is the final stalled cycle and the next edge declares timeout.
  assign last_wait = (32'(wcnt) + 32'd1) >= MEM_TIMEOUT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= M_IDLE;
      wcnt      <= '0;
      mem_error <= 1'b0;
    end else begin
      case (state)
        M_IDLE: begin
          if (memop && !dmem_ready) begin
            if (last_wait) begin
              state     <= M_ERR;
              mem_error <= 1'b1;
            end else begin
              state <= M_WAIT;
              wcnt  <= WCNT_W'(1);
            end
          end
        end
        M_WAIT: begin
          if (!memop || dmem_ready) begin
            state <= M_IDLE;
            wcnt  <= '0;
          end else if (last_wait) begin
            state     <= M_ERR;
            mem_error <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        M_ERR: state <= M_ERR;
        default: begin
          state <= M_IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use, EX redirects and DMem wait handling,
// plus saturating hazard counters. All stall/flush outputs are combinational.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hazard_ctrl_if.master  hz,
  output logic                    MemError,
  output logic [CNT_W-1:0]        LoadUseCnt,
  output logic [CNT_W-1:0]        MemWaitCnt,
  output logic [CNT_W-1:0]        RedirectCnt
);

  haz_req_t   req;
  haz_rsp_t   rsp;
  logic [1:0] state;
  logic       memop, dmem_req, memwait, loaduse;
  logic       win_mw, win_rd, win_lu;

  assign req = hz.req;

  assign memop    = req.EXMEMMemRead | req.EXMEMMemWrite;
  assign dmem_req = !rst && memop && (state != M_ERR);
  assign memwait  = dmem_req && !req.DMemReady;
  assign loaduse  = req.IDEXMemRead && (req.IDEXRegRd != REG_ZERO) &&
                    (src_hit(req.IFIDUseRs1, req.IFIDRs1, req.IDEXRegRd) ||
                     src_hit(req.IFIDUseRs2, req.IFIDRs2, req.IDEXRegRd));

  dmem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .memop      (memop),
    .dmem_ready (req.DMemReady),
    .state      (state),
    .mem_error  (MemError)
  );

  always_comb begin
    rsp    = '0;
    win_mw = 1'b0;
    win_rd = 1'b0;
    win_lu = 1'b0;
    if (rst) begin
      rsp.IFIDFlush  = 1'b1;
      rsp.IDEXFlush  = 1'b1;
      rsp.EXMEMFlush = 1'b1;
      rsp.MEMWBFlush = 1'b1;
    end else if (state == M_ERR) begin
      rsp.PCStall    = 1'b1;
      rsp.IFIDStall  = 1'b1;
      rsp.IDEXStall  = 1'b1;
      rsp.EXMEMStall = 1'b1;
      rsp.MEMWBStall = 1'b1;
    end else if (memwait) begin
      // Redirect/load-use sources are frozen here and re-evaluate on release.
      win_mw         = 1'b1;
      rsp.PCStall    = 1'b1;
      rsp.IFIDStall  = 1'b1;
      rsp.IDEXStall  = 1'b1;
      rsp.EXMEMStall = 1'b1;
      rsp.MEMWBFlush = 1'b1;
    end else if (req.EXRedirect) begin
      win_rd        = 1'b1;
      rsp.IFIDFlush = 1'b1;
      rsp.IDEXFlush = 1'b1;
    end else if (loaduse) begin
      win_lu        = 1'b1;
      rsp.PCStall   = 1'b1;
      rsp.IFIDStall = 1'b1;
      rsp.IDEXFlush = 1'b1;
    end
    rsp.DMemReq = dmem_req;
  end

  assign hz.rsp = rsp;

  always_ff @(posedge clk) begin
    if (rst) begin
      LoadUseCnt  <= '0;
      MemWaitCnt  <= '0;
      RedirectCnt <= '0;
    end else begin
      if (win_lu && (LoadUseCnt  != '1)) LoadUseCnt  <= LoadUseCnt  + CNT_W'(1);
      if (win_mw && (MemWaitCnt  != '1)) MemWaitCnt  <= MemWaitCnt  + CNT_W'(1);
      if (win_rd && (RedirectCnt != '1)) RedirectCnt <= RedirectCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a negedge monitor compares.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hif();
  logic          MemError;
  logic [CW-1:0] LoadUseCnt, MemWaitCnt, RedirectCnt;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .hz          (hif),
    .MemError    (MemError),
    .LoadUseCnt  (LoadUseCnt),
    .MemWaitCnt  (MemWaitCnt),
    .RedirectCnt (RedirectCnt)
  );

  typedef struct {
    logic [4:0] stall;   // PC, IFID, IDEX, EXMEM, MEMWB
    logic [3:0] flush;   // IFID, IDEX, EXMEM, MEMWB
    logic       dreq;
    logic       merr;
    int         lu, mw, rd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model: consecutive-wait count, sticky error, hazard tallies
  int m_waits = 0, m_lu = 0, m_mw = 0, m_rd = 0;
  bit m_err = 0;

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input haz_req_t rq);
    exp_t e;
    bit memop, dreq, mwait, luse;
    @(posedge clk);
    #1;
    rst     = r;
    hif.req = rq;
    memop = rq.EXMEMMemRead || rq.EXMEMMemWrite;
    dreq  = !r && memop && !m_err;
    mwait = dreq && !rq.DMemReady;
    luse  = rq.IDEXMemRead && (rq.IDEXRegRd != 0) &&
            ((rq.IFIDUseRs1 && rq.IFIDRs1 == rq.IDEXRegRd) ||
             (rq.IFIDUseRs2 && rq.IFIDRs2 == rq.IDEXRegRd));
    e.stall = 5'b00000;
    e.flush = 4'b0000;
    e.dreq  = dreq;
    e.merr  = m_err;
    e.lu = m_lu; e.mw = m_mw; e.rd = m_rd;
    if (r)               e.flush = 4'b1111;
    else if (m_err)      e.stall = 5'b11111;
    else if (mwait)      begin e.stall = 5'b11110; e.flush = 4'b0001; m_mw = sat_inc(m_mw); end
    else if (rq.EXRedirect) begin e.flush = 4'b1100; m_rd = sat_inc(m_rd); end
    else if (luse)       begin e.stall = 5'b11000; e.flush = 4'b0100; m_lu = sat_inc(m_lu); end
    if (r) begin
      m_waits = 0; m_err = 0; m_lu = 0; m_mw = 0; m_rd = 0;
    end else if (mwait) begin
      m_waits++;
      if (m_waits >= TO) m_err = 1;
    end else begin
      m_waits = 0;
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", int'({hif.rsp.PCStall, hif.rsp.IFIDStall, hif.rsp.IDEXStall,
                         hif.rsp.EXMEMStall, hif.rsp.MEMWBStall}), int'(e.stall));
      chk("flush", int'({hif.rsp.IFIDFlush, hif.rsp.IDEXFlush, hif.rsp.EXMEMFlush,
                         hif.rsp.MEMWBFlush}), int'(e.flush));
      chk("dmemreq", int'(hif.rsp.DMemReq), int'(e.dreq));
      chk("memerror", int'(MemError), int'(e.merr));
      chk("loadusecnt", int'(LoadUseCnt), e.lu);
      chk("memwaitcnt", int'(MemWaitCnt), e.mw);
      chk("redirectcnt", int'(RedirectCnt), e.rd);
    end
  end

  function automatic haz_req_t lu_req(input logic [4:0] rd);
    haz_req_t t = '0;
    t.IDEXMemRead = 1'b1;
    t.IDEXRegRd   = rd;
    t.IFIDRs1     = rd;
    t.IFIDUseRs1  = 1'b1;
    return t;
  endfunction

  function automatic haz_req_t mem_req(input logic ready, input logic redir);
    haz_req_t t = '0;
    t.EXMEMMemRead = 1'b1;
    t.DMemReady    = ready;
    t.EXRedirect   = redir;
    return t;
  endfunction

  initial begin
    haz_req_t rq;
    hif.req = '0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);

    apply(1'b1, '0);                 // reset cycle: flushes forced
    apply(1'b0, lu_req(5'd5));       // load-use
    apply(1'b0, '0);
    apply(1'b0, lu_req(5'd0));       // x0 load: no hazard
    rq = lu_req(5'd5); rq.EXRedirect = 1'b1;
    apply(1'b0, rq);                 // redirect beats load-use
    apply(1'b0, '0);

    for (int i = 0; i < 3; i++) apply(1'b0, mem_req(1'b0, 1'b1)); // 3-cycle wait, redirect held
    apply(1'b0, mem_req(1'b1, 1'b1));                            // release: redirect wins
    apply(1'b0, '0);

    for (int i = 0; i < 6; i++) apply(1'b0, mem_req(1'b0, 1'b0)); // timeout
    apply(1'b0, lu_req(5'd3));
    apply(1'b1, '0);
    apply(1'b0, '0);

    for (int i = 0; i < 20; i++) apply(1'b0, lu_req(5'd7));      // saturation
    apply(1'b0, '0);

    for (int i = 0; i < 2; i++) apply(1'b0, mem_req(1'b0, 1'b0));
    apply(1'b1, mem_req(1'b0, 1'b0));                            // rst mid-wait
    apply(1'b0, '0);
    apply(1'b0, mem_req(1'b0, 1'b0));
    apply(1'b0, mem_req(1'b1, 1'b0));

    for (int i = 0; i < 2000; i++) begin
      rq.IFIDRs1       = 5'($urandom_range(0, 3));
      rq.IFIDRs2       = 5'($urandom_range(0, 3));
      rq.IFIDUseRs1    = 1'($urandom_range(0, 1));
      rq.IFIDUseRs2    = 1'($urandom_range(0, 1));
      rq.IDEXMemRead   = 1'($urandom_range(0, 1));
      rq.IDEXRegRd     = 5'($urandom_range(0, 3));
      rq.EXRedirect    = ($urandom_range(0, 4) == 0);
      rq.EXMEMMemRead  = ($urandom_range(0, 2) == 0);
      rq.EXMEMMemWrite = ($urandom_range(0, 3) == 0);
      rq.DMemReady     = ($urandom_range(0, 2) == 0);
      apply(($urandom_range(0, 59) == 0), rq);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
